// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared opcodes, flag bit positions, FSM encoding and the
// ALU reply payload used by the UART-ALU command sequencer.
package uart_alu_pkg;

   localparam int unsigned ALU_W = 8;
   localparam int unsigned OP_W  = 6;

   // Opcode field values (bits [5:0] of the opcode byte)
   localparam logic [OP_W-1:0] OP_ADD = 6'h20;
   localparam logic [OP_W-1:0] OP_SUB = 6'h22;
   localparam logic [OP_W-1:0] OP_AND = 6'h24;
   localparam logic [OP_W-1:0] OP_OR  = 6'h25;
   localparam logic [OP_W-1:0] OP_XOR = 6'h26;
   localparam logic [OP_W-1:0] OP_NOR = 6'h27;
   localparam logic [OP_W-1:0] OP_SRL = 6'h02;
   localparam logic [OP_W-1:0] OP_SRA = 6'h03;

   // Flag byte bit positions
   localparam int unsigned FLG_ZERO  = 0;
   localparam int unsigned FLG_CARRY = 1;
   localparam int unsigned FLG_OVF   = 2;
   localparam int unsigned FLG_NEG   = 3;
   localparam int unsigned FLG_INV   = 4;

   typedef enum logic [2:0] {
      S_GET_A    = 3'd0,
      S_GET_B    = 3'd1,
      S_GET_OP   = 3'd2,
      S_EXEC     = 3'd3,
      S_SEND_RES = 3'd4,
      S_SEND_FLG = 3'd5
   } state_t;

   // Reply payload produced by the ALU
   typedef struct packed {
      logic [ALU_W-1:0] result;
      logic [ALU_W-1:0] flags;
   } alu_rsp_t;

   // True when the opcode field names a supported operation
   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOR) ||
             (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/uart_alu_ctrl_alu_core.sv
// alu_core: combinational 8-bit ALU with flag generation.
// Ports:
//   i_a, i_b   operands (i_b is also the unsigned shift amount)
//   i_op       full opcode byte; bits above NB_OP must be zero
//   o_rsp      result and flags byte
module alu_core
   import uart_alu_pkg::*;
#(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_OP   = 6
) (
   input  logic [NB_DATA-1:0] i_a,
   input  logic [NB_DATA-1:0] i_b,
   input  logic [NB_DATA-1:0] i_op,
   output alu_rsp_t           o_rsp
);

   localparam int unsigned MSB  = NB_DATA - 1;
   localparam int unsigned SH_W = $clog2(NB_DATA);

   logic [NB_DATA:0]   sum;
   logic [NB_DATA:0]   diff;
   logic [NB_DATA-1:0] res;
   logic               carry;
   logic               ovf;
   logic               inv;
   logic               big_shift;

   // Extra top bit holds carry-out on add and borrow on subtract
   assign sum       = {1'b0, i_a} + {1'b0, i_b};
   assign diff      = {1'b0, i_a} - {1'b0, i_b};
   assign big_shift = (i_b >= NB_DATA'(NB_DATA));

   // Operation select
   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      inv   = 1'b0;
      if ((i_op[NB_DATA-1:NB_OP] != '0) || !is_valid_op(i_op[NB_OP-1:0])) begin
         inv = 1'b1;
      end else begin
         case (i_op[NB_OP-1:0])
            OP_ADD: begin
               res   = sum[NB_DATA-1:0];
               carry = sum[NB_DATA];
               ovf   = (i_a[MSB] == i_b[MSB]) && (sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
               res   = diff[NB_DATA-1:0];
               carry = diff[NB_DATA];
               ovf   = (i_a[MSB] != i_b[MSB]) && (diff[MSB] != i_a[MSB]);
            end
            OP_AND: res = i_a & i_b;
            OP_OR:  res = i_a | i_b;
            OP_XOR: res = i_a ^ i_b;
            OP_NOR: res = ~(i_a | i_b);
            OP_SRL: res = big_shift ? '0 : (i_a >> i_b[SH_W-1:0]);
            OP_SRA: res = big_shift ? {NB_DATA{i_a[MSB]}}
                                    : NB_DATA'($signed(i_a) >>> i_b[SH_W-1:0]);
            default: inv = 1'b1;
         endcase
      end
   end

   // Flag packing; an invalid opcode reports only the invalid bit
   always_comb begin
      o_rsp.result = '0;
      o_rsp.flags  = '0;
      if (inv) begin
         o_rsp.flags[FLG_INV] = 1'b1;
      end else begin
         o_rsp.result           = res;
         o_rsp.flags[FLG_ZERO]  = (res == '0);
         o_rsp.flags[FLG_CARRY] = carry;
         o_rsp.flags[FLG_OVF]   = ovf;
         o_rsp.flags[FLG_NEG]   = res[MSB];
      end
   end

endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: UART-ALU chip core. Pops a 3-byte frame (A, B, opcode) from
// the RX FIFO, runs one ALU operation and pushes result then flags into the
// TX FIFO. Partial frames are dropped after an inter-byte timeout.
// Ports:
//   i_clk, i_reset        clock, async active-low reset
//   i_rx_empty, i_rx_data RX FIFO status / head byte
//   o_read_uart           RX pop strobe
//   i_tx_full             TX FIFO full
//   o_write_uart, o_tx_data TX push strobe / byte
//   o_result, o_flags     last executed result and flags
//   o_busy                high outside S_GET_A
//   o_frame_err           one-cycle pulse when a partial frame times out
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int unsigned NB_DATA        = 8,
   parameter int unsigned NB_OP          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned NB_TIMEOUT     = 20
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_empty,
   input  logic [NB_DATA-1:0] i_rx_data,
   output logic               o_read_uart,
   input  logic               i_tx_full,
   output logic               o_write_uart,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic [NB_DATA-1:0] o_result,
   output logic [NB_DATA-1:0] o_flags,
   output logic               o_busy,
   output logic               o_frame_err
);

   localparam logic                  TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [NB_TIMEOUT-1:0] TMO_LAST = TMO_EN ? NB_TIMEOUT'(TIMEOUT_CYCLES - 1)
                                                       : '0;

   state_t                  state;
   logic [NB_DATA-1:0]      a_q;
   logic [NB_DATA-1:0]      b_q;
   logic [NB_DATA-1:0]      op_q;
   logic [NB_TIMEOUT-1:0]   tmo_cnt;
   alu_rsp_t                alu_rsp;
   logic                    in_get;
   logic                    in_frame;
   logic                    in_send;
   logic                    tmo_hit;

   alu_core #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) u_alu (
      .i_a   (a_q),
      .i_b   (b_q),
      .i_op  (op_q),
      .o_rsp (alu_rsp)
   );

   assign in_get   = (state == S_GET_A) || (state == S_GET_B) || (state == S_GET_OP);
   assign in_frame = (state == S_GET_B) || (state == S_GET_OP);
   assign in_send  = (state == S_SEND_RES) || (state == S_SEND_FLG);

   // Strobes are gated by reset so nothing escapes while reset is held
   assign o_read_uart  = i_reset && in_get  && !i_rx_empty;
   assign o_write_uart = i_reset && in_send && !i_tx_full;
   assign o_busy       = (state != S_GET_A);

   // Only an idle cycle can expire the timer, so a same-cycle byte always wins
   assign tmo_hit = TMO_EN && in_frame && i_rx_empty && (tmo_cnt == TMO_LAST);

   // Byte presented to the TX FIFO
   always_comb begin
      o_tx_data = '0;
      case (state)
         S_SEND_RES: o_tx_data = o_result;
         S_SEND_FLG: o_tx_data = o_flags;
         default:    o_tx_data = '0;
      endcase
   end

   // Sequencer, capture registers, timeout counter and registered outputs
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= S_GET_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         tmo_cnt     <= '0;
         o_result    <= '0;
         o_flags     <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         case (state)
            S_GET_A: begin
               tmo_cnt <= '0;
               if (o_read_uart) begin
                  a_q   <= i_rx_data;
                  state <= S_GET_B;
               end
            end
            S_GET_B, S_GET_OP: begin
               if (o_read_uart) begin
                  tmo_cnt <= '0;
                  if (state == S_GET_B) begin
                     b_q   <= i_rx_data;
                     state <= S_GET_OP;
                  end else begin
                     op_q  <= i_rx_data;
                     state <= S_EXEC;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt     <= '0;
                  a_q         <= '0;
                  b_q         <= '0;
                  o_frame_err <= 1'b1;
                  state       <= S_GET_A;
               end else if (TMO_EN) begin
                  tmo_cnt <= tmo_cnt + NB_TIMEOUT'(1);
               end
            end
            S_EXEC: begin
               o_result <= alu_rsp.result;
               o_flags  <= alu_rsp.flags;
               state    <= S_SEND_RES;
            end
            S_SEND_RES: begin
               if (o_write_uart) state <= S_SEND_FLG;
            end
            S_SEND_FLG: begin
               if (o_write_uart) state <= S_GET_A;
            end
            default: state <= S_GET_A;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: drives the RX/TX FIFO handshakes and
// checks replies, latency, timeout, backpressure and reset behaviour.
module tb_uart_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_empty = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       tx_full = 1'b0;
   logic       read_uart;
   logic       write_uart;
   logic [7:0] tx_data;
   logic [7:0] result;
   logic [7:0] flags;
   logic       busy;
   logic       frame_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int pop_viol = 0;
   int push_viol = 0;
   int err_cnt = 0;
   int last_pop_cyc = 0;
   int first_push_cyc = 0;
   int op_pop_cyc = 0;
   int snap;
   logic [7:0] push_q[$];
   int         push_cyc_q[$];

   uart_alu_ctrl #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (50),
      .NB_TIMEOUT     (20)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_rx_empty   (rx_empty),
      .i_rx_data    (rx_data),
      .o_read_uart  (read_uart),
      .i_tx_full    (tx_full),
      .o_write_uart (write_uart),
      .o_tx_data    (tx_data),
      .o_result     (result),
      .o_flags      (flags),
      .o_busy       (busy),
      .o_frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change just after posedge, so strobes are stable at negedge
   always @(negedge clk) begin
      if (read_uart) begin
         pop_cnt++;
         last_pop_cyc = cyc;
         if (rx_empty) pop_viol++;
      end
      if (write_uart) begin
         push_q.push_back(tx_data);
         push_cyc_q.push_back(cyc);
         if (tx_full) push_viol++;
      end
      if (frame_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_pop(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (read_uart) begin
            @(posedge clk);
            #1;
            rx_empty = 1'b1;
            done = 1'b1;
         end
      end
      check({tag, " pop_seen"}, 32'(done), 32'd1);
   endtask

   task automatic push_rx(input logic [7:0] b, input int gap, input string tag);
      tick(gap);
      rx_data  = b;
      rx_empty = 1'b0;
      wait_pop(tag);
   endtask

   task automatic wait_reply(input string tag, input logic [7:0] er, input logic [7:0] ef,
                             input bit chk_idle);
      int i = 0;
      while (push_q.size() < 2 && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      tick(1);
      check({tag, " push_count"}, 32'(push_q.size()), 32'd2);
      first_push_cyc = (push_cyc_q.size() > 0) ? push_cyc_q[0] : -1;
      check({tag, " tx_result"}, 32'(push_q[0]), 32'(er));
      check({tag, " tx_flags"},  32'(push_q[1]), 32'(ef));
      check({tag, " o_result"},  32'(result), 32'(er));
      check({tag, " o_flags"},   32'(flags), 32'(ef));
      if (chk_idle) check({tag, " busy_idle"}, 32'(busy), 32'd0);
      push_q.delete();
      push_cyc_q.delete();
   endtask

   task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] er, input logic [7:0] ef);
      push_rx(a, 0, tag);
      push_rx(b, 0, tag);
      push_rx(op, 0, tag);
      op_pop_cyc = last_pop_cyc;
      wait_reply(tag, er, ef, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"},      32'(busy), 32'd0);
      check({tag, " result"},    32'(result), 32'd0);
      check({tag, " flags"},     32'(flags), 32'd0);
      check({tag, " tx_data"},   32'(tx_data), 32'd0);
      check({tag, " strobes"},   32'({read_uart, write_uart, frame_err}), 32'd0);
   endtask

   initial begin
      // Reset state
      tick(3);
      check_zero("reset");
      rst_n = 1'b1;
      tick(2);

      // ADD with overflow, plus first-push latency from the opcode pop
      snap = pop_cnt;
      frame("add_ovf", 8'h7F, 8'h01, 8'h20, 8'h80, 8'h0C);
      check("add_ovf pops", 32'(pop_cnt - snap), 32'd3);
      check("add_ovf latency", 32'(first_push_cyc - op_pop_cyc), 32'd2);

      // SUB: zero, borrow, signed overflow; ADD carry wrap to zero
      frame("sub_zero",   8'h05, 8'h05, 8'h22, 8'h00, 8'h01);
      frame("sub_borrow", 8'h03, 8'h05, 8'h22, 8'hFE, 8'h0A);
      frame("sub_ovf",    8'h80, 8'h01, 8'h22, 8'h7F, 8'h04);
      frame("add_carry",  8'hFF, 8'h01, 8'h20, 8'h00, 8'h03);

      // Shifts, including amounts at and beyond the width
      frame("sra_big", 8'h80, 8'h09, 8'h03, 8'hFF, 8'h08);
      frame("srl_8",   8'h80, 8'h08, 8'h02, 8'h00, 8'h01);
      frame("sra_1",   8'h40, 8'h01, 8'h03, 8'h20, 8'h00);
      frame("srl_7",   8'h81, 8'h07, 8'h02, 8'h01, 8'h00);

      // Logic ops and invalid opcodes
      frame("and",     8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00);
      frame("xor",     8'hAA, 8'hAA, 8'h26, 8'h00, 8'h01);
      frame("inv_hi",  8'h12, 8'h34, 8'hE0, 8'h00, 8'h10);
      frame("inv_lo",  8'h12, 8'h34, 8'h21, 8'h00, 8'h10);
      frame("nor",     8'h00, 8'h00, 8'h27, 8'hFF, 8'h08);

      // Timeout after A and B: one error pulse, no reply, result kept
      snap = err_cnt;
      push_rx(8'h11, 0, "tmo");
      push_rx(8'h22, 0, "tmo");
      tick(55);
      check("tmo err_pulses", 32'(err_cnt - snap), 32'd1);
      check("tmo no_push",    32'(push_q.size()), 32'd0);
      check("tmo busy",       32'(busy), 32'd0);
      check("tmo result",     32'(result), 32'hFF);
      check("tmo flags",      32'(flags), 32'h08);

      // Gaps just under the limit: every pop restarts the timer
      snap = err_cnt;
      push_rx(8'h0F, 45, "gap");
      push_rx(8'hF0, 45, "gap");
      push_rx(8'h25, 45, "gap");
      wait_reply("gap_or", 8'hFF, 8'h08, 1'b1);
      check("gap no_err", 32'(err_cnt - snap), 32'd0);

      // Backpressure: TX full through S_SEND_RES, next A byte waiting in RX
      tx_full = 1'b1;
      push_rx(8'h10, 2, "bp");
      push_rx(8'h20, 3, "bp");
      push_rx(8'h20, 0, "bp");
      tick(3);
      snap = pop_cnt;
      rx_data  = 8'h01;
      rx_empty = 1'b0;
      tick(7);
      check("bp no_push", 32'(push_q.size()), 32'd0);
      check("bp no_pop",  32'(pop_cnt - snap), 32'd0);
      check("bp busy",    32'(busy), 32'd1);
      tx_full = 1'b0;
      wait_pop("bp_next");
      wait_reply("bp", 8'h30, 8'h00, 1'b0);
      push_rx(8'h02, 4, "bp2");
      push_rx(8'h22, 6, "bp2");
      wait_reply("bp2_sub", 8'hFF, 8'h0A, 1'b1);

      // Async reset while waiting for the opcode
      push_rx(8'h33, 0, "rst1");
      push_rx(8'h44, 0, "rst1");
      tick(2);
      #2 rst_n = 1'b0;
      #1 check_zero("rst_getop");
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Async reset while the flags byte is held by a full TX FIFO
      tx_full = 1'b1;
      push_rx(8'h05, 0, "rst2");
      push_rx(8'h06, 0, "rst2");
      push_rx(8'h20, 0, "rst2");
      tick(2);
      tx_full = 1'b0;
      tick(1);
      tx_full = 1'b1;
      tick(3);
      check("rst2 one_push", 32'(push_q.size()), 32'd1);
      check("rst2 res_byte", 32'(push_q[0]), 32'h0B);
      check("rst2 busy",     32'(busy), 32'd1);
      #3 rst_n = 1'b0;
      #1 check_zero("rst_sendflg");
      tick(2);
      tx_full = 1'b0;
      rst_n = 1'b1;
      push_q.delete();
      push_cyc_q.delete();
      tick(5);
      check("rst2 no_more_push", 32'(push_q.size()), 32'd0);

      // Normal operation after reset
      frame("post_rst", 8'h01, 8'h02, 8'h20, 8'h03, 8'h00);

      check("pop_while_empty",  32'(pop_viol), 32'd0);
      check("push_while_full",  32'(push_viol), 32'd0);
      check("total_frame_errs", 32'(err_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Command sequencer directly downstream of the UART interface; consumes bytes from its RX FIFO and produces bytes into its TX FIFO.
Collects a 3-byte frame (operand A, operand B, opcode), executes one 8-bit ALU operation, and returns a 2-byte reply (result, flags).
Includes an inter-byte timeout that discards partial frames. Top level is the UART-ALU chip core.

Parameters:
NB_DATA, 8, data/operand width (only 8 supported)
NB_OP, 6, opcode field width
TIMEOUT_CYCLES, 1000000, idle clocks allowed between frame bytes; 0 disables the timeout
NB_TIMEOUT, 20, timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_empty  in  1  RX FIFO empty
i_rx_data  in  NB_DATA  RX FIFO head byte, valid when i_rx_empty=0
o_read_uart  out  1  RX FIFO pop strobe
i_tx_full  in  1  TX FIFO full
o_write_uart  out  1  TX FIFO push strobe
o_tx_data  out  NB_DATA  byte to push
o_result  out  NB_DATA  last registered ALU result
o_flags  out  NB_DATA  last registered flags byte
o_busy  out  1  high in any state other than S_GET_A
o_frame_err  out  1  one-cycle pulse on timeout discard

Behaviour:
- Reset (async assert, sync release): state S_GET_A; A, B, opcode, o_result, o_flags and timeout counter = 0; all strobes = 0; o_busy = 0.
- States: S_GET_A -> S_GET_B -> S_GET_OP -> S_EXEC -> S_SEND_RES -> S_SEND_FLG -> S_GET_A.
- GET states: o_read_uart = (i_rx_empty==0), combinational. On that edge, capture i_rx_data into A, B or opcode and advance. Exactly one pop per byte. No pop while empty.
- S_EXEC: exactly 1 cycle. Register the ALU output into o_result and o_flags.
- SEND states: o_write_uart = (i_tx_full==0), combinational. o_tx_data = o_result in S_SEND_RES and o_flags in S_SEND_FLG; 0 elsewhere. Advance on push; hold indefinitely while full.
- Latency: frame of back-to-back bytes gives the first push 2 cycles after the opcode pop edge (EXEC, then SEND_RES) when TX is not full.
- Opcodes (bits [5:0]; bits [7:6] must be 0):
  - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRL 0x02, SRA 0x03.
  - Shift amount = B (unsigned). B >= 8 gives 0x00 for SRL and sign fill for SRA.
- Flags:
  - bit0 zero (result==0).
  - bit1 carry: ADD carry-out, SUB borrow (A<B unsigned); 0 otherwise.
  - bit2 signed overflow: ADD/SUB only.
  - bit3 negative = result[7].
  - bit4 invalid opcode.
  - bits [7:5] = 0.
- Invalid opcode: result 0x00, flags 0x10 exactly. The reply is still sent.
- Timeout: counter clears on every pop and whenever in S_GET_A.
  - In S_GET_B or S_GET_OP it increments each cycle with i_rx_empty=1.
  - On reaching TIMEOUT_CYCLES: go to S_GET_A, pulse o_frame_err, discard A/B. o_result and o_flags stay unchanged.
  - A byte arriving on the same cycle as the timeout: the pop wins and the counter clears.
  - No timeout in EXEC or SEND states.
- Reset mid-frame or mid-reply: abort immediately with no further strobes. The FIFOs reset alongside.

Decomposition:
- Package uart_alu_pkg:
  - opcode localparams (OP_ADD..OP_SRA)
  - flag bit indices (FLG_ZERO, FLG_CARRY, FLG_OVF, FLG_NEG, FLG_INV)
  - state encodings.
- Sub-module alu_core: purely combinational; inputs A, B, opcode; outputs result and flags. Instantiated once.
- The FSM, capture registers and timeout counter live in uart_alu_ctrl.

Test Plan:
- ADD frame 0x7F,0x01,0x20 -> pops 3 bytes, pushes 0x80 then 0x0C (ovf+neg); o_busy low after the second push.
- SUB frames:
  - 0x05,0x05,0x22 -> 0x00, 0x01.
  - 0x03,0x05,0x22 -> 0xFE, 0x0A (borrow+neg).
- Shift and invalid opcode:
  - SRA 0x80,0x09,0x03 -> 0xFF, 0x08.
  - Invalid opcode 0xE0 (bits 7:6 set) -> 0x00, 0x10.
- Timeout (TIMEOUT_CYCLES=50): send A, B, then stall 50 cycles -> one o_frame_err pulse, no pushes. Next frame 0x0F,0xF0,0x25 -> 0xFF, 0x08.
- Backpressure: hold i_tx_full=1 for 10 cycles entering S_SEND_RES -> no o_write_uart. On release, exactly 2 pushes in the correct order. Interleave RX bytes arriving with gaps, and check there are no pops while i_rx_empty=1.
- Assert i_reset low during S_GET_OP and again during S_SEND_FLG -> all outputs 0 asynchronously. After release, a full ADD frame 0x01,0x02,0x20 -> 0x03, 0x00.
